// File: rtl/bin2bcd_blank_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3) with leading-zero blank mask
// and overflow saturation. It feeds the 8-digit 7-segment display driver.
module bin2bcd_blank_seq #(
  parameter int unsigned BIN_W  = 27,
  parameter int unsigned DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_in_i,
  output logic [4*DIGITS-1:0]   digits_out_o,
  output logic [DIGITS-1:0]     blank_out_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ovf_o
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e             state_q;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_pend_q;
  logic [BCD_W-1:0]   digits_q;
  logic [DIGITS-1:0]  blank_q;
  logic               busy_q, done_q, ovf_q;

  logic [BCD_W-1:0]         adj;
  logic [BCD_W+BIN_W-1:0]   sh;
  logic [DIGITS-1:0]        blank_c;
  logic                     zero_above;

  // Add-3 on every nibble >= 5, then shift the {bcd, bin} pair left by one.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    sh    = {adj, bin_q} << 1;
    bcd_d = sh[BIN_W +: BCD_W];
    bin_d = sh[BIN_W-1:0];
  end

  // A digit blanks only when it and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    blank_c    = '0;
    zero_above = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_above = zero_above & (bcd_q[4*i +: 4] == 4'd0);
      blank_c[i] = zero_above;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      blank_q    <= {{(DIGITS-1){1'b1}}, 1'b0};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            bin_q      <= bin_in_i;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= (64'(bin_in_i) > MAX_VAL);
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1)) state_q <= FINISH;
        end
        FINISH: begin
          if (ovf_pend_q) begin
            digits_q <= {DIGITS{4'h9}};
            blank_q  <= '0;
          end else begin
            digits_q <= bcd_q;
            blank_q  <= blank_c;
          end
          ovf_q   <= ovf_pend_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign digits_out_o = digits_q;
  assign blank_out_o  = blank_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_bin2bcd_blank_seq.sv
// Self-checking bench for bin2bcd_blank_seq: directed vector table, handshake and
// async-reset sequences, and a random sweep against a decimal-arithmetic model.
module tb_bin2bcd_blank_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [26:0] bin;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic        busy, done, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_blank_seq #(.BIN_W(27), .DIGITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .bin_in_i     (bin),
    .digits_out_o (digits),
    .blank_out_o  (blank),
    .busy_o       (busy),
    .done_o       (done),
    .ovf_o        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] v;
    logic [31:0] dig;
    logic [7:0]  blk;
    logic        ov;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain decimal arithmetic, digit i is blank iff value < 10^i.
  task automatic model(input logic [26:0] v, output logic [31:0] dig,
                       output logic [7:0] blk, output logic ov);
    longint t, p;
    dig = '0;
    blk = '0;
    ov  = (longint'(v) > 64'd99_999_999);
    if (ov) begin
      dig = 32'h9999_9999;
    end else begin
      t = longint'(v);
      for (int i = 0; i < 8; i++) begin
        dig[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
      p = 1;
      for (int i = 1; i < 8; i++) begin
        p = p * 10;
        blk[i] = (longint'(v) < p);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic launch(input logic [26:0] v);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("done_low_after_accept", 64'(done), 64'd0);
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask

  // Waits for DONE, optionally re-pulsing START with alt at sample restart_at.
  task automatic wait_done(input logic [31:0] e_dig, input logic [7:0] e_blk,
                           input logic e_ov, input int restart_at,
                           input logic [26:0] alt);
    int lat, busy_cnt;
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 60) begin
      if (busy) busy_cnt++;
      if (lat == restart_at) begin
        start = 1'b1;
        bin   = alt;
      end else begin
        start = 1'b0;
        bin   = 27'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("done_latency", 64'(lat), 64'd28);
    chk("busy_cycles", 64'(busy_cnt), 64'd28);
    chk("busy_in_done", 64'(busy), 64'd0);
    chk("digits", 64'(digits), 64'(e_dig));
    chk("blank", 64'(blank), 64'(e_blk));
    chk("ovf", 64'(ovf), 64'(e_ov));
  endtask

  vec_t tbl[11];
  logic [31:0] m_dig;
  logic [7:0]  m_blk;
  logic        m_ov;
  logic [26:0] rv;
  bit          saw_done;

  initial begin
    tbl[0]  = '{27'd0,           32'h0000_0000, 8'hFE, 1'b0};
    tbl[1]  = '{27'd12_345_678,  32'h1234_5678, 8'h00, 1'b0};
    tbl[2]  = '{27'd907,         32'h0000_0907, 8'hF8, 1'b0};
    tbl[3]  = '{27'd99_999_999,  32'h9999_9999, 8'h00, 1'b0};
    tbl[4]  = '{27'd100_000_000, 32'h9999_9999, 8'h00, 1'b1};
    tbl[5]  = '{27'd5,           32'h0000_0005, 8'hFE, 1'b0};
    tbl[6]  = '{27'h7FF_FFFF,    32'h9999_9999, 8'h00, 1'b1};
    tbl[7]  = '{27'd10,          32'h0000_0010, 8'hFC, 1'b0};
    tbl[8]  = '{27'd1,           32'h0000_0001, 8'hFE, 1'b0};
    tbl[9]  = '{27'd10_000_000,  32'h1000_0000, 8'h00, 1'b0};
    tbl[10] = '{27'd9_999_999,   32'h0999_9999, 8'h80, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    #12 rst = 1'b0;
    @(negedge clk);
    chk("rst_digits", 64'(digits), 64'd0);
    chk("rst_blank", 64'(blank), 64'hFE);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);

    // Directed table, back-to-back (each START issued in the previous DONE cycle).
    for (int i = 0; i < 11; i++) begin
      launch(tbl[i].v);
      wait_done(tbl[i].dig, tbl[i].blk, tbl[i].ov, -1, '0);
    end

    // Re-pulsed START with a new value mid-conversion is ignored.
    launch(27'd12_345_678);
    wait_done(32'h1234_5678, 8'h00, 1'b0, 5, 27'd907);

    // Overflow result present, then async reset at shift 10 of the next conversion.
    launch(27'd100_000_000);
    wait_done(32'h9999_9999, 8'h00, 1'b1, -1, '0);
    launch(27'd12_345_678);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_digits", 64'(digits), 64'd0);
    chk("arst_blank", 64'(blank), 64'hFE);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("no_done_after_rst", 64'(saw_done), 64'd0);
    chk("idle_after_rst", 64'(busy), 64'd0);
    launch(27'd4_096);
    wait_done(32'h0000_4096, 8'hF0, 1'b0, -1, '0);

    // Random sweep with occasional idle gaps; outputs must hold while idle.
    m_dig = 32'h0000_4096;
    m_blk = 8'hF0;
    m_ov  = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) begin
          @(negedge clk);
          bin = 27'($urandom);
        end
        chk("hold_digits", 64'(digits), 64'(m_dig));
        chk("hold_blank", 64'(blank), 64'(m_blk));
        chk("hold_ovf", 64'(ovf), 64'(m_ov));
      end
      rv = 27'($urandom_range(0, 32'h07FF_FFFF));
      model(rv, m_dig, m_blk, m_ov);
      launch(rv);
      wait_done(m_dig, m_blk, m_ov, -1, '0);
    end

    @(negedge clk);
    chk("done_single_cycle", 64'(done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
